// File: rtl/exec_cc_stage_if.sv
// exec_cc_stage_if: valid/ready bus between the ALU, the CC stage and memory/write-back
interface exec_cc_stage_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_vale;
    logic             in_ovf;
    logic             in_set_cc;
    logic [3:0]       in_ifun;
    logic             in_use_cnd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_vale;
    logic             out_cnd;

    modport master (
        output in_valid, in_vale, in_ovf, in_set_cc, in_ifun, in_use_cnd, out_ready,
        input  in_ready, out_valid, out_vale, out_cnd
    );

    modport slave (
        input  in_valid, in_vale, in_ovf, in_set_cc, in_ifun, in_use_cnd, out_ready,
        output in_ready, out_valid, out_vale, out_cnd
    );
endinterface

// File: rtl/exec_cc_stage.sv
// exec_cc_stage: Y86-64 execute back end; registers valE, owns the CC register, evaluates cnd.
// Optional CC snapshot/restore for misprediction recovery is enabled by EXEC_CC_SNAPSHOT_EN.
module exec_cc_stage #(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    exec_cc_stage_if.slave      bus,
    output logic [2:0]          cc
`ifdef EXEC_CC_SNAPSHOT_EN
    ,
    input  logic                cc_save,
    input  logic                cc_restore,
    output logic [2:0]          cc_snap
`endif
);
    logic             out_valid_q;
    logic [WIDTH-1:0] out_vale_q;
    logic             out_cnd_q;
    logic             accept;
    logic             sf_xor_of;
    logic             cnd;
    logic [2:0]       cc_upd;
    logic [2:0]       cc_nxt;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vale  = out_vale_q;
    assign bus.out_cnd   = out_cnd_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sf_xor_of     = cc[1] ^ cc[0];

    // Condition evaluated against the CC value held before this cycle's update
    always_comb begin
        cnd = !bus.in_use_cnd     ? 1'b0 :
              bus.in_ifun == 4'd0 ? 1'b1 :
              bus.in_ifun == 4'd1 ? sf_xor_of | cc[2] :
              bus.in_ifun == 4'd2 ? sf_xor_of :
              bus.in_ifun == 4'd3 ? cc[2] :
              bus.in_ifun == 4'd4 ? !cc[2] :
              bus.in_ifun == 4'd5 ? !sf_xor_of :
              bus.in_ifun == 4'd6 ? !sf_xor_of && !cc[2] :
                                    1'b0;
    end

    // Flag derivation for OPq accepts; a restore overrides it when present
    always_comb begin
        cc_upd = (accept && bus.in_set_cc) ?
                 {bus.in_vale == '0, bus.in_vale[WIDTH-1], bus.in_ovf} : cc;
`ifdef EXEC_CC_SNAPSHOT_EN
        cc_nxt = cc_restore ? cc_snap : cc_upd;
`else
        cc_nxt = cc_upd;
`endif
    end

    // Output register and condition-code register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_vale_q  <= '0;
            out_cnd_q   <= 1'b0;
            cc          <= 3'b100;
        end else begin
            out_valid_q <= accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
            if (accept) begin
                out_vale_q <= bus.in_vale;
                out_cnd_q  <= cnd;
            end
            cc <= cc_nxt;
        end
    end

`ifdef EXEC_CC_SNAPSHOT_EN
    // Snapshot captures the pre-update CC; save+restore together swaps the two
    always_ff @(posedge clk) begin
        if (rst)
            cc_snap <= 3'b100;
        else if (cc_save)
            cc_snap <= cc;
    end
`endif
endmodule

// File: tb/tb_exec_cc_stage.sv
// tb_exec_cc_stage: vector table plus scoreboard bench for exec_cc_stage (covers EXEC_CC_SNAPSHOT_EN when defined)
module tb_exec_cc_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cc;
`ifdef EXEC_CC_SNAPSHOT_EN
    logic       cc_save;
    logic       cc_restore;
    logic [2:0] cc_snap;
`endif
    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [64:0] sb[$];

    exec_cc_stage_if #(.WIDTH(64)) bus ();

    exec_cc_stage #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cc         (cc)
`ifdef EXEC_CC_SNAPSHOT_EN
        ,
        .cc_save    (cc_save),
        .cc_restore (cc_restore),
        .cc_snap    (cc_snap)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] v;
        logic        o;
        logic        s;
        logic [3:0]  f;
        logic        u;
        logic [2:0]  ecc;
        logic        ecnd;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each transfer out of the stage must match the oldest accepted entry
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got vale %0h with no pending entry", bus.out_vale);
            end else begin
                logic [64:0] e;
                e = sb.pop_front();
                pops++;
                chk("sb_vale", bus.out_vale, e[64:1]);
                chk("sb_cnd", {63'd0, bus.out_cnd}, {63'd0, e[0]});
            end
        end
    end

    task automatic send(input logic [63:0] v, input logic o, input logic s, input logic [3:0] f,
                        input logic u, input logic [2:0] ecc, input logic ecnd);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_vale = v;
        bus.in_ovf = o;
        bus.in_set_cc = s;
        bus.in_ifun = f;
        bus.in_use_cnd = u;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back({v, ecnd});
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
        chk("cc_after", {61'd0, cc}, {61'd0, ecc});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_vale = '0;
        bus.in_ovf = 1'b0;
        bus.in_set_cc = 1'b0;
        bus.in_ifun = '0;
        bus.in_use_cnd = 1'b0;
        bus.out_ready = 1'b1;
`ifdef EXEC_CC_SNAPSHOT_EN
        cc_save = 1'b0;
        cc_restore = 1'b0;
`endif
        tbl[0]  = '{64'd0,                   1'b0, 1'b1, 4'd0, 1'b0, 3'b100, 1'b0};
        tbl[1]  = '{64'd123,                 1'b0, 1'b0, 4'd3, 1'b1, 3'b100, 1'b1};
        tbl[2]  = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'd0, 1'b0, 3'b011, 1'b0};
        tbl[3]  = '{64'd1,                   1'b0, 1'b0, 4'd2, 1'b1, 3'b011, 1'b0};
        tbl[4]  = '{64'd2,                   1'b0, 1'b0, 4'd1, 1'b1, 3'b011, 1'b0};
        tbl[5]  = '{64'd3,                   1'b0, 1'b0, 4'd5, 1'b1, 3'b011, 1'b1};
        tbl[6]  = '{64'd4,                   1'b0, 1'b0, 4'd6, 1'b1, 3'b011, 1'b1};
        tbl[7]  = '{64'd5,                   1'b0, 1'b0, 4'd4, 1'b1, 3'b011, 1'b1};
        tbl[8]  = '{64'd6,                   1'b0, 1'b0, 4'd0, 1'b1, 3'b011, 1'b1};
        tbl[9]  = '{64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 4'd3, 1'b1, 3'b010, 1'b0};
        tbl[10] = '{64'd7,                   1'b0, 1'b0, 4'd2, 1'b1, 3'b010, 1'b1};
        tbl[11] = '{64'd8,                   1'b0, 1'b0, 4'd1, 1'b1, 3'b010, 1'b1};
        tbl[12] = '{64'd9,                   1'b0, 1'b0, 4'd5, 1'b1, 3'b010, 1'b0};
        tbl[13] = '{64'd10,                  1'b0, 1'b0, 4'd6, 1'b1, 3'b010, 1'b0};
        tbl[14] = '{64'd11,                  1'b0, 1'b0, 4'd3, 1'b1, 3'b010, 1'b0};
        tbl[15] = '{64'd12,                  1'b0, 1'b0, 4'd4, 1'b1, 3'b010, 1'b1};
        tbl[16] = '{64'd5,                   1'b0, 1'b1, 4'd2, 1'b1, 3'b000, 1'b1};
        tbl[17] = '{64'd13,                  1'b0, 1'b0, 4'd6, 1'b1, 3'b000, 1'b1};
        tbl[18] = '{64'd14,                  1'b0, 1'b0, 4'd0, 1'b0, 3'b000, 1'b0};

        // Reset with a would-be accept pending: reset must win
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_vale = 64'h55;
        bus.in_set_cc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cc", {61'd0, cc}, 64'b100);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_vale", bus.out_vale, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b0;
        bus.in_set_cc = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 19; i++)
            send(tbl[i].v, tbl[i].o, tbl[i].s, tbl[i].f, tbl[i].u, tbl[i].ecc, tbl[i].ecnd);

        // Unused condition codes always yield 0, even with CC = 000 where "always"/ge/g are true
        for (int f = 7; f < 16; f++)
            send(64'd100 + 64'(f), 1'b0, 1'b0, 4'(f), 1'b1, 3'b000, 1'b0);

        // Backpressure: A accepted, B stalled for 3 cycles, then B, C, D stream at full rate
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_vale = 64'h7;
        bus.in_ovf = 1'b0;
        bus.in_set_cc = 1'b1;
        bus.in_ifun = 4'd0;
        bus.in_use_cnd = 1'b0;
        @(negedge clk);
        chk("bp_a_ready", {63'd0, bus.in_ready}, 64'd1);
        sb.push_back({64'h7, 1'b0});
        @(posedge clk);
        #1;
        bus.in_vale = 64'd0;
        bus.in_set_cc = 1'b1;
        bus.in_ifun = 4'd4;
        bus.in_use_cnd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_out_vale", bus.out_vale, 64'h7);
            chk("bp_cc", {61'd0, cc}, 64'b000);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_ready", {63'd0, bus.in_ready}, 64'd1);
        sb.push_back({64'd0, 1'b1});
        @(posedge clk);
        #1;
        bus.in_set_cc = 1'b0;
        bus.in_vale = 64'h77;
        bus.in_ifun = 4'd3;
        @(negedge clk);
        sb.push_back({64'h77, 1'b1});
        @(posedge clk);
        #1;
        bus.in_vale = 64'h8000_0000_0000_0000;
        bus.in_set_cc = 1'b1;
        bus.in_ifun = 4'd0;
        bus.in_use_cnd = 1'b0;
        @(negedge clk);
        sb.push_back({64'h8000_0000_0000_0000, 1'b0});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_set_cc = 1'b0;
        chk("bp_cc_final", {61'd0, cc}, 64'b010);
        repeat (3) @(posedge clk);
        #1;

`ifdef EXEC_CC_SNAPSHOT_EN
        // Save 010, overwrite with 100, then restore during a set_cc accept
        cc_save = 1'b1;
        @(posedge clk);
        #1;
        cc_save = 1'b0;
        chk("snap_saved", {61'd0, cc_snap}, 64'b010);
        send(64'd0, 1'b0, 1'b1, 4'd0, 1'b0, 3'b100, 1'b0);
        cc_restore = 1'b1;
        send(64'h8000_0000_0000_0000, 1'b1, 1'b1, 4'd0, 1'b0, 3'b010, 1'b0);
        cc_restore = 1'b0;
        send(64'd0, 1'b0, 1'b1, 4'd0, 1'b0, 3'b100, 1'b0);
        cc_save = 1'b1;
        cc_restore = 1'b1;
        @(posedge clk);
        #1;
        cc_save = 1'b0;
        cc_restore = 1'b0;
        chk("swap_cc", {61'd0, cc}, 64'b010);
        chk("swap_snap", {61'd0, cc_snap}, 64'b100);
        repeat (3) @(posedge clk);
        #1;
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
`ifdef EXEC_CC_SNAPSHOT_EN
        chk("sb_pops", 64'(pops), 64'd35);
`else
        chk("sb_pops", 64'(pops), 64'd32);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
